// File: rtl/bus_terminal_fifo.sv
// bus_terminal_fifo: bus endpoint with TX FIFO toward the bus and ID-filtered RX FIFO toward user logic
module bus_terminal_fifo #(
  parameter int pckg_sz = 16,
  parameter int depth = 8,
  parameter logic [7:0] id = 8'd0,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  logic               clk,
  input  logic               reset,
  output logic               pndng,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               pop,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  input  logic               tx_wr,
  input  logic [pckg_sz-1:0] tx_data,
  output logic               tx_full,
  input  logic               rx_rd,
  output logic [pckg_sz-1:0] rx_data,
  output logic               rx_empty,
  output logic [15:0]        rx_drop,
  output logic               pop_err
);
  localparam int aw = $clog2(depth);
  logic [pckg_sz-1:0] tx_mem [depth];
  logic [pckg_sz-1:0] rx_mem [depth];
  logic [aw-1:0] tx_head, tx_tail, rx_head, rx_tail;
  logic [aw:0] tx_cnt, rx_cnt;
  logic tx_we, tx_re, rx_we, rx_re, rx_full, accept, drop;
  logic [7:0] dst;
  assign pndng = tx_cnt != '0;
  assign tx_full = tx_cnt == (aw+1)'(depth);
  assign rx_empty = rx_cnt == '0;
  assign rx_full = rx_cnt == (aw+1)'(depth);
  assign D_pop = pndng ? tx_mem[tx_head] : '0;
  assign rx_data = rx_empty ? '0 : rx_mem[rx_head];
  // When full, a simultaneous pop frees the slot the write lands in, so both proceed
  always_comb begin
    dst = D_push[pckg_sz-1 -: 8];
    tx_re = pop & pndng;
    tx_we = tx_wr & (!tx_full | tx_re);
    rx_re = rx_rd & !rx_empty;
    accept = push & (dst == id | dst == broadcast);
    rx_we = accept & (!rx_full | rx_re);
    drop = push & !rx_we;
  end
  // Storage arrays need no reset: outputs are masked while the counts say empty
  always_ff @(posedge clk) begin
    if (tx_we) tx_mem[tx_tail] <= tx_data;
    if (rx_we) rx_mem[rx_tail] <= D_push;
  end
  // Pointer, count and status registers for both FIFOs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_head <= '0;
      tx_tail <= '0;
      tx_cnt <= '0;
      rx_head <= '0;
      rx_tail <= '0;
      rx_cnt <= '0;
      rx_drop <= '0;
      pop_err <= 1'b0;
    end else begin
      if (tx_we) tx_tail <= tx_tail + 1'b1;
      if (tx_re) tx_head <= tx_head + 1'b1;
      tx_cnt <= tx_cnt + (aw+1)'(tx_we) - (aw+1)'(tx_re);
      if (rx_we) rx_tail <= rx_tail + 1'b1;
      if (rx_re) rx_head <= rx_head + 1'b1;
      rx_cnt <= rx_cnt + (aw+1)'(rx_we) - (aw+1)'(rx_re);
      if (drop && rx_drop != 16'hFFFF) rx_drop <= rx_drop + 16'd1;
      if (pop && !pndng) pop_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_bus_terminal_fifo.sv
// tb_bus_terminal_fifo: directed self-checking bench for bus_terminal_fifo
module tb_bus_terminal_fifo;
  logic clk = 1'b0, reset = 1'b0;
  logic pndng, pop = 1'b0, push = 1'b0, tx_wr = 1'b0, tx_full, rx_rd = 1'b0, rx_empty, pop_err;
  logic [15:0] D_pop, D_push = '0, tx_data = '0, rx_data, rx_drop;
  int n_chk = 0, n_fail = 0;
  bus_terminal_fifo #(.pckg_sz(16), .depth(8), .id(8'd3), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop), .push(push),
    .D_push(D_push), .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full), .rx_rd(rx_rd),
    .rx_data(rx_data), .rx_empty(rx_empty), .rx_drop(rx_drop), .pop_err(pop_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pndng_held", 16'(pndng), 16'd0);
    reset = 1'b1;
    tick();
    chk("rst_pndng", 16'(pndng), 16'd0);
    chk("rst_rx_empty", 16'(rx_empty), 16'd1);
    chk("rst_tx_full", 16'(tx_full), 16'd0);
    chk("rst_rx_drop", rx_drop, 16'd0);
    chk("rst_pop_err", 16'(pop_err), 16'd0);
    chk("rst_D_pop", D_pop, 16'd0);
    chk("rst_rx_data", rx_data, 16'd0);
    tx_wr = 1'b1;
    tx_data = 16'h0A01;
    tick();
    chk("tx_lat_pndng", 16'(pndng), 16'd1);
    chk("tx_lat_dpop", D_pop, 16'h0A01);
    tx_data = 16'h0A02;
    tick();
    tx_data = 16'h0A03;
    tick();
    tx_wr = 1'b0;
    pop = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      chk("tx_order", D_pop, 16'h0A00 + 16'(i));
      tick();
    end
    pop = 1'b0;
    chk("tx_drained_pndng", 16'(pndng), 16'd0);
    chk("tx_drained_dpop", D_pop, 16'd0);
    tx_wr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tx_data = 16'h1000 + 16'(i);
      tick();
    end
    chk("tx_full_8", 16'(tx_full), 16'd1);
    tx_data = 16'h10FF;
    tick();
    chk("tx_9th_full", 16'(tx_full), 16'd1);
    chk("tx_9th_head", D_pop, 16'h1000);
    pop = 1'b1;
    tx_data = 16'h1008;
    tick();
    tx_wr = 1'b0;
    chk("tx_full_popwr", 16'(tx_full), 16'd1);
    for (int i = 1; i <= 8; i++) begin
      chk("tx_wrap_order", D_pop, 16'h1000 + 16'(i));
      tick();
    end
    pop = 1'b0;
    chk("tx_wrap_empty", 16'(pndng), 16'd0);
    chk("tx_no_pop_err", 16'(pop_err), 16'd0);
    push = 1'b1;
    D_push = 16'h0355;
    tick();
    chk("rx_lat_empty", 16'(rx_empty), 16'd0);
    chk("rx_lat_data", rx_data, 16'h0355);
    D_push = 16'h0455;
    tick();
    chk("rx_id_drop", rx_drop, 16'd1);
    D_push = 16'hFF66;
    tick();
    push = 1'b0;
    chk("rx_first", rx_data, 16'h0355);
    rx_rd = 1'b1;
    tick();
    chk("rx_bcast", rx_data, 16'hFF66);
    tick();
    chk("rx_drained", 16'(rx_empty), 16'd1);
    chk("rx_drained_data", rx_data, 16'd0);
    tick();
    rx_rd = 1'b0;
    chk("rx_rd_empty", 16'(rx_empty), 16'd1);
    chk("rx_rd_empty_drop", rx_drop, 16'd1);
    push = 1'b1;
    for (int i = 0; i < 9; i++) begin
      D_push = 16'h0300 + 16'(i);
      tick();
    end
    chk("rx_ovf_drop", rx_drop, 16'd2);
    chk("rx_ovf_head", rx_data, 16'h0300);
    D_push = 16'h0399;
    rx_rd = 1'b1;
    tick();
    push = 1'b0;
    chk("rx_full_rdpush_drop", rx_drop, 16'd2);
    chk("rx_full_rdpush_empty", 16'(rx_empty), 16'd0);
    for (int i = 1; i <= 8; i++) begin
      chk("rx_ovf_order", rx_data, (i == 8) ? 16'h0399 : 16'h0300 + 16'(i));
      tick();
    end
    rx_rd = 1'b0;
    chk("rx_ovf_drained", 16'(rx_empty), 16'd1);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    chk("pop_err_set", 16'(pop_err), 16'd1);
    tick();
    chk("pop_err_sticky", 16'(pop_err), 16'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("pop_err_cleared", 16'(pop_err), 16'd0);
    tx_wr = 1'b1;
    pop = 1'b1;
    tx_data = 16'h0B00;
    tick();
    pop = 1'b0;
    chk("empty_wrpop_pndng", 16'(pndng), 16'd1);
    chk("empty_wrpop_dpop", D_pop, 16'h0B00);
    chk("empty_wrpop_err", 16'(pop_err), 16'd1);
    for (int i = 1; i < 4; i++) begin
      tx_data = 16'h0B00 + 16'(i);
      tick();
    end
    tx_wr = 1'b0;
    chk("burst_head", D_pop, 16'h0B00);
    #2;
    reset = 1'b0;
    #1;
    chk("async_pndng", 16'(pndng), 16'd0);
    chk("async_pop_err", 16'(pop_err), 16'd0);
    chk("async_dpop", D_pop, 16'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("post_rst_pndng", 16'(pndng), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
